// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-side responder for the single-cycle cpu load/store port. Provides a
//   word-organised RAM (combinational read, synchronous write) and a 16-byte
//   memory-mapped I/O window with four registers:
//     +0x0 CYCLE  free-running counter, read/write
//     +0x4 GPIO   output register, read/write
//     +0x8 ERR    sticky access-error flag; any write clears it
//     +0xC        reserved: reads 0, writes ignored
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-high
//   dataAddr   byte address from the cpu
//   writeData  store data from the cpu
//   we         1 = store this cycle
//   readData   load data, combinational from dataAddr
//   gpioOut    GPIO register value
//   accessErr  sticky error flag (misaligned access, or store to unmapped)
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataAddr,
  input  logic [31:0] writeData,
  input  logic        we,
  output logic [31:0] readData,
  output logic [31:0] gpioOut,
  output logic        accessErr
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  logic [31:0] mem [DEPTH];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] gpio_q,  gpio_d;
  logic        err_q,   err_d;

  // Decode
  logic          misaligned;
  logic          ram_hit;
  logic          io_hit;
  logic [AW-1:0] word_idx;
  logic [1:0]    io_off;
  logic          wr_ok;

  assign misaligned = (dataAddr[1:0] != 2'b00);
  assign ram_hit    = (dataAddr < RAM_BYTES);
  assign io_hit     = (dataAddr[31:4] == IO_BASE[31:4]);
  assign word_idx   = dataAddr[AW+1:2];
  assign io_off     = dataAddr[3:2];
  // A store only takes effect when aligned and out of reset.
  assign wr_ok      = we && !misaligned && !reset;

  // Read path
  always_comb begin
    readData = 32'h0;
    if (!reset && !misaligned) begin
      if (ram_hit) begin
        readData = mem[word_idx];
      end else if (io_hit) begin
        case (io_off)
          2'd0:    readData = cycle_q;
          2'd1:    readData = gpio_q;
          2'd2:    readData = {31'b0, err_q};
          default: readData = 32'h0;
        endcase
      end
    end
  end

  // RAM write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok && ram_hit) begin
      mem[word_idx] <= writeData;
    end
  end

  // I/O register next state
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    gpio_d  = gpio_q;
    err_d   = err_q;

    // A CYCLE store overrides the increment for this edge.
    if (wr_ok && io_hit && io_off == 2'd0) cycle_d = writeData;
    if (wr_ok && io_hit && io_off == 2'd1) gpio_d  = writeData;
    if (wr_ok && io_hit && io_off == 2'd2) err_d   = 1'b0;

    // Set has priority over the ERR clear. Unmapped reads are harmless.
    if (misaligned || (we && !ram_hit && !io_hit)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= 32'h0;
      gpio_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      gpio_q  <= gpio_d;
      err_q   <= err_d;
    end
  end

  assign gpioOut   = gpio_q;
  assign accessErr = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Inputs change 1 ns after the rising
//   edge and outputs are sampled a further 1 ns later, well clear of the edge.
//   Expected values are pushed to exp_q and popped when the output is sampled.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] dataAddr;
  logic [31:0] writeData;
  logic        we;
  logic [31:0] readData;
  logic [31:0] gpioOut;
  logic        accessErr;

  logic [31:0] exp_q[$];
  int          total  = 0;
  int          passed = 0;

  localparam logic [31:0] A_CYC  = 32'hFFFF_FFF0;
  localparam logic [31:0] A_GPIO = 32'hFFFF_FFF4;
  localparam logic [31:0] A_ERR  = 32'hFFFF_FFF8;
  localparam logic [31:0] A_RSV  = 32'hFFFF_FFFC;

  data_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .dataAddr  (dataAddr),
    .writeData (writeData),
    .we        (we),
    .readData  (readData),
    .gpioOut   (gpioOut),
    .accessErr (accessErr)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] d, input logic w);
    dataAddr  = a;
    writeData = d;
    we        = w;
    #1;
  endtask

  // scoreboard
  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h but expected queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  initial begin
    reset     = 1'b1;
    dataAddr  = A_CYC;
    writeData = 32'h0;
    we        = 1'b0;

    // Reset then idle
    cyc(); cyc();
    reset = 1'b0;
    drv(A_CYC, 32'h0, 1'b0);
    expect_val(32'h0); chk("reset_read_zero", readData);
    expect_val(32'h0); chk("reset_gpio", gpioOut);
    expect_val(32'h0); chk("reset_err", {31'b0, accessErr});
    cyc(); cyc(); cyc();
    expect_val(32'd3); chk("cycle_after_3", readData);

    // Store then load (preload two words so the old value is known)
    drv(32'h0, 32'h1111_1111, 1'b1); cyc();
    drv(32'h4, 32'h2222_2222, 1'b1); cyc();
    drv(32'h0, 32'h0000_01FE, 1'b1);
    expect_val(32'h1111_1111); chk("rdw_old_value", readData);
    cyc();
    drv(32'h0, 32'h0, 1'b0);
    expect_val(32'h0000_01FE); chk("ram0_new_value", readData);
    drv(32'h4, 32'h0, 1'b0);
    expect_val(32'h2222_2222); chk("ram1_unaffected", readData);

    // Last RAM word boundary
    drv(32'h3FC, 32'hCAFE_F00D, 1'b1); cyc();
    drv(32'h3FC, 32'h0, 1'b0);
    expect_val(32'hCAFE_F00D); chk("ram_last_word", readData);
    expect_val(32'h0); chk("ram_last_no_err", {31'b0, accessErr});

    // GPIO load
    drv(A_GPIO, 32'hA5A5_0001, 1'b1);
    expect_val(32'h0); chk("gpio_before_edge", gpioOut);
    cyc();
    drv(A_GPIO, 32'h0, 1'b0);
    expect_val(32'hA5A5_0001); chk("gpio_out", gpioOut);
    expect_val(32'hA5A5_0001); chk("gpio_read", readData);

    // CYCLE load and wrap
    drv(A_CYC, 32'hFFFF_FFFE, 1'b1); cyc();
    drv(A_CYC, 32'h0, 1'b0);
    expect_val(32'hFFFF_FFFE); chk("cycle_loaded", readData);
    cyc();
    expect_val(32'hFFFF_FFFF); chk("cycle_inc", readData);
    cyc();
    expect_val(32'h0); chk("cycle_wrap", readData);

    // Reserved register
    drv(A_RSV, 32'h1234, 1'b1);
    expect_val(32'h0); chk("rsv_read_w", readData);
    cyc();
    drv(A_RSV, 32'h0, 1'b0);
    expect_val(32'h0); chk("rsv_read", readData);
    expect_val(32'h0); chk("rsv_no_err", {31'b0, accessErr});

    // Misaligned store
    drv(32'h6, 32'h1234, 1'b1);
    expect_val(32'h0); chk("misal_read_zero", readData);
    expect_val(32'h0); chk("misal_err_not_yet", {31'b0, accessErr});
    cyc();
    drv(32'h4, 32'h0, 1'b0);
    expect_val(32'h2222_2222); chk("misal_ram_unchanged", readData);
    expect_val(32'h1); chk("misal_err_set", {31'b0, accessErr});
    drv(A_ERR, 32'h0, 1'b0);
    expect_val(32'h1); chk("err_reg_read", readData);
    cyc();
    drv(A_ERR, 32'h0, 1'b1);
    expect_val(32'h1); chk("err_reg_old_on_write", readData);
    cyc();
    drv(A_CYC, 32'h0, 1'b0);
    expect_val(32'h0); chk("err_cleared", {31'b0, accessErr});

    // Unmapped accesses
    drv(32'h0001_0000, 32'h0, 1'b0);
    expect_val(32'h0); chk("unmapped_read", readData);
    cyc();
    expect_val(32'h0); chk("unmapped_read_no_err", {31'b0, accessErr});
    drv(32'h0001_0000, 32'hBEEF, 1'b1); cyc();
    drv(A_CYC, 32'h0, 1'b0);
    expect_val(32'h1); chk("unmapped_write_err", {31'b0, accessErr});
    drv(32'h0, 32'h0, 1'b0);
    expect_val(32'h0000_01FE); chk("unmapped_ram0_intact", readData);
    drv(32'h4, 32'h0, 1'b0);
    expect_val(32'h2222_2222); chk("unmapped_ram1_intact", readData);

    // Reset mid-operation
    drv(A_GPIO, 32'h55, 1'b1); cyc();
    drv(A_CYC, 32'd100, 1'b1); cyc();
    drv(A_CYC, 32'h0, 1'b0);
    expect_val(32'd100); chk("cycle_100", readData);
    reset = 1'b1;
    drv(32'h0, 32'hDEAD, 1'b1);
    expect_val(32'h0); chk("read_zero_in_reset", readData);
    cyc();
    expect_val(32'h0); chk("midrst_gpio", gpioOut);
    expect_val(32'h0); chk("midrst_err", {31'b0, accessErr});
    reset = 1'b0;
    drv(A_CYC, 32'h0, 1'b0);
    expect_val(32'h0); chk("midrst_cycle", readData);
    drv(32'h0, 32'h0, 1'b0);
    expect_val(32'h0000_01FE); chk("midrst_ram_kept", readData);

    // final report
    total++;
    assert (exp_q.size() == 0) passed++;
    else $error("FAIL exp_q_drained: observed %0d expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
